vend_sequencer: RTL

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vend_sequencer.sv
// Coin-operated vending sequencer: accumulates a balance, dispenses affordable
// items, and pays back change greedily (largest coin first) on timeout or request.
module vend_sequencer #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 31,
  parameter int WAIT_TIME  = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_COINS-1:0]    i_input_coin,
  input  logic [NUM_ITEMS-1:0]    i_select_item,
  input  logic                    i_trigger_return,
  input  logic [32*NUM_COINS-1:0] i_coin_value,
  input  logic [32*NUM_ITEMS-1:0] i_item_price,
  output logic [NUM_ITEMS-1:0]    o_available_item,
  output logic [NUM_ITEMS-1:0]    o_output_item,
  output logic [NUM_COINS-1:0]    o_return_coin,
  output logic [TOTAL_BITS-1:0]   o_current_total,
  output logic                    o_busy
);
  // Extra headroom so coin sums and 32-bit prices compare without wrapping.
  localparam int SW = ((TOTAL_BITS > 32) ? TOTAL_BITS : 32) + $clog2(NUM_COINS + 1) + 1;
  localparam int CW = (WAIT_TIME > 1) ? $clog2(WAIT_TIME + 1) : 1;
  localparam logic [SW-1:0] MAX_TOTAL = {{(SW-TOTAL_BITS){1'b0}}, {TOTAL_BITS{1'b1}}};
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_TIME);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RETURN} state_t;

  state_t                r_state;
  logic [TOTAL_BITS-1:0] r_total;
  logic [CW-1:0]         r_cnt;
  logic [NUM_ITEMS-1:0]  r_output_item;
  logic [NUM_COINS-1:0]  r_return_coin;
  logic                  r_busy;

  logic [SW-1:0]         w_total_ext;
  logic [SW-1:0]         w_coin_sum;
  logic [SW-1:0]         w_new_total;
  logic [SW-1:0]         w_sel_price;
  logic [TOTAL_BITS-1:0] w_ret_value;
  logic [NUM_COINS-1:0]  w_ret_onehot;
  logic                  w_coin_any;
  logic                  w_coin_ok;
  logic                  w_sel_ok;
  logic                  w_ret_found;

  always_comb begin
    w_total_ext = SW'(r_total);
    w_coin_sum  = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (i_input_coin[k]) w_coin_sum = w_coin_sum + SW'(i_coin_value[32*k +: 32]);
    end
    w_coin_any  = |i_input_coin;
    w_new_total = w_total_ext + w_coin_sum;
    w_coin_ok   = (w_new_total <= MAX_TOTAL);

    w_sel_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (i_select_item[i]) w_sel_price = w_sel_price | SW'(i_item_price[32*i +: 32]);
    end
    w_sel_ok = $onehot(i_select_item) && (w_sel_price <= w_total_ext);

    // Coin values ascend with index, so the last fitting coin is the largest.
    w_ret_onehot = '0;
    w_ret_value  = '0;
    w_ret_found  = 1'b0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (SW'(i_coin_value[32*k +: 32]) <= w_total_ext) begin
        w_ret_onehot    = '0;
        w_ret_onehot[k] = 1'b1;
        w_ret_value     = TOTAL_BITS'(i_coin_value[32*k +: 32]);
        w_ret_found     = 1'b1;
      end
    end

    for (int i = 0; i < NUM_ITEMS; i++) begin
      o_available_item[i] = (r_state == S_HOLD) && (SW'(i_item_price[32*i +: 32]) <= w_total_ext);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_total       <= '0;
      r_cnt         <= '0;
      r_output_item <= '0;
      r_return_coin <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_output_item <= '0;
      r_return_coin <= '0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (i_trigger_return) begin
            if (r_state == S_HOLD) begin
              r_state <= S_RETURN;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
            end
          end else if (w_coin_any) begin
            // An overflowing coin cycle leaves everything untouched.
            if (w_coin_ok) begin
              r_total <= w_new_total[TOTAL_BITS-1:0];
              r_state <= S_HOLD;
              r_cnt   <= WAIT_LOAD;
            end
          end else if (r_state == S_HOLD) begin
            if (w_sel_ok) begin
              r_total       <= r_total - w_sel_price[TOTAL_BITS-1:0];
              r_output_item <= i_select_item;
              r_cnt         <= WAIT_LOAD;
              if (w_sel_price == w_total_ext) r_state <= S_IDLE;
            end else if (r_cnt <= CW'(1)) begin
              r_state <= S_RETURN;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        S_RETURN: begin
          if (r_total == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_ret_found) begin
            r_return_coin <= w_ret_onehot;
            r_total       <= r_total - w_ret_value;
          end else begin
            // Residue smaller than any coin is forfeited.
            r_total <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_output_item   = r_output_item;
  assign o_return_coin   = r_return_coin;
  assign o_current_total = r_total;
  assign o_busy          = r_busy;

endmodule
